// File: rtl/fetch_queue.sv
// fetch_queue: instruction prefetch FIFO feeding the decoder from a req/ack memory port,
// with flush-and-redirect on jump and fetch stop on halt.
module fetch_queue #(
    parameter int         DEPTH    = 4,
    parameter logic [7:0] RESET_PC = 8'h00
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic                     mem_req,
    output logic [7:0]               mem_addr,
    input  logic                     mem_ack,
    input  logic [31:0]              mem_rdata,
    output logic [31:0]              ir,
    output logic [7:0]               ir_pc,
    output logic                     ir_valid,
    input  logic                     ir_take,
    input  logic                     jmp_inst,
    input  logic [7:0]               jmp_address,
    input  logic                     hlt_inst,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   level
);
    localparam int PW = $clog2(DEPTH);
    localparam int LW = PW + 1;
    localparam logic [LW-1:0] FULL = LW'(DEPTH);

    typedef enum logic [1:0] {IDLE, WAIT, DRAIN, HALT} state_t;

    state_t          state, state_nxt;
    logic [31:0]     q_data [DEPTH];
    logic [7:0]      q_pc   [DEPTH];
    logic [PW-1:0]   rd_ptr, wr_ptr;
    logic [LW-1:0]   level_nxt;
    logic [7:0]      fetch_pc;
    logic            discard, active, ack, hlt, jmp, pop, enq;

    assign mem_req  = state == WAIT || state == DRAIN;
    assign halted   = state == HALT;
    assign ir_valid = level != '0 && state != HALT;
    assign ir       = q_data[rd_ptr];
    assign ir_pc    = q_pc[rd_ptr];

    always_comb begin
        active    = state == IDLE || state == WAIT;
        ack       = mem_req && mem_ack;
        hlt       = hlt_inst && active;
        jmp       = jmp_inst && active && !hlt_inst;
        pop       = ir_take && ir_valid && !hlt;
        enq       = ack && state == WAIT && !discard && !jmp && !hlt;
        level_nxt = (jmp || hlt) ? '0 : level + LW'(enq) - LW'(pop);
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = hlt ? HALT : (level < FULL || jmp) ? WAIT : IDLE;
            WAIT:    state_nxt = hlt ? (ack ? HALT : DRAIN) : (level_nxt < FULL ? WAIT : IDLE);
            DRAIN:   state_nxt = ack ? HALT : DRAIN;
            default: state_nxt = HALT;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            level    <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            fetch_pc <= RESET_PC;
            mem_addr <= RESET_PC;
            discard  <= 1'b0;
        end else begin
            state  <= state_nxt;
            level  <= level_nxt;
            rd_ptr <= (jmp || hlt) ? '0 : rd_ptr + PW'(pop);
            wr_ptr <= (jmp || hlt) ? '0 : wr_ptr + PW'(enq);
            if (jmp) begin
                // an in-flight request keeps its address; its data is dropped via discard
                fetch_pc <= jmp_address;
                discard  <= state == WAIT && !ack;
                if (state == IDLE || ack)
                    mem_addr <= jmp_address;
            end else if (ack && state == WAIT) begin
                discard  <= 1'b0;
                if (!discard)
                    fetch_pc <= fetch_pc + 8'd1;
                mem_addr <= discard ? fetch_pc : fetch_pc + 8'd1;
            end else if (state == IDLE) begin
                mem_addr <= fetch_pc;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            q_data[wr_ptr] <= mem_rdata;
            q_pc[wr_ptr]   <= mem_addr;
        end
    end
endmodule
